// File: rtl/synth_pkg.sv
// synth_pkg: shared envelope state encoding and gain width
package synth_pkg;
  localparam int ENV_GAIN_W = 16;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;
endpackage

// File: rtl/envelope_gain_fsm.sv
// envelope_gain_fsm: ADSR state and gain register; ports clk, reset (async low), upd_i, note_start_i, note_done_rise_i, gain_o, state_o
module envelope_gain_fsm
  import synth_pkg::*;
#(
  parameter logic [ENV_GAIN_W-1:0] ATTACK_STEP   = 16'h0400,
  parameter logic [ENV_GAIN_W-1:0] DECAY_STEP    = 16'h0100,
  parameter logic [ENV_GAIN_W-1:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [ENV_GAIN_W-1:0] RELEASE_STEP  = 16'h0080
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  upd_i,
  input  logic                  note_start_i,
  input  logic                  note_done_rise_i,
  output logic [ENV_GAIN_W-1:0] gain_o,
  output env_state_t            state_o
);
  env_state_t state_q, state_d;
  logic [ENV_GAIN_W-1:0] gain_q, gain_d;
  logic [ENV_GAIN_W:0] sum;
  assign sum = {1'b0, gain_q} + {1'b0, ATTACK_STEP};
  always_comb begin
    state_d = state_q;
    gain_d = gain_q;
    // events take the transition only; the new state's step waits for the next update
    if (note_start_i) state_d = ATTACK;
    else if (note_done_rise_i && (state_q inside {ATTACK, DECAY, SUSTAIN})) state_d = RELEASE;
    else if (upd_i) begin
      case (state_q)
        IDLE: gain_d = '0;
        ATTACK: begin
          gain_d = sum[ENV_GAIN_W] ? '1 : sum[ENV_GAIN_W-1:0];
          state_d = (sum >= {1'b0, {ENV_GAIN_W{1'b1}}}) ? DECAY : ATTACK;
        end
        DECAY: begin
          gain_d = ({1'b0, gain_q} <= {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP}) ? SUSTAIN_LEVEL : gain_q - DECAY_STEP;
          state_d = (gain_d == SUSTAIN_LEVEL) ? SUSTAIN : DECAY;
        end
        RELEASE: begin
          gain_d = (gain_q <= RELEASE_STEP) ? '0 : gain_q - RELEASE_STEP;
          state_d = (gain_q <= RELEASE_STEP) ? IDLE : RELEASE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gain_q <= '0;
    end else begin
      state_q <= state_d;
      gain_q <= gain_d;
    end
  end
  assign gain_o = gain_q;
  assign state_o = state_q;
endmodule

// File: rtl/envelope_shaper.sv
// envelope_shaper: ADSR gain applied to note_player samples; ports clk, reset (async low), play_enable, note_start, note_done, sample_in/_valid, beat (ENV_BEAT_RATE_EN only), sample_out/_valid
module envelope_shaper
  import synth_pkg::*;
#(
  parameter logic [ENV_GAIN_W-1:0] ATTACK_STEP   = 16'h0400,
  parameter logic [ENV_GAIN_W-1:0] DECAY_STEP    = 16'h0100,
  parameter logic [ENV_GAIN_W-1:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [ENV_GAIN_W-1:0] RELEASE_STEP  = 16'h0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic        note_start,
  input  logic        note_done,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
`ifdef ENV_BEAT_RATE_EN
  input  logic        beat,
`endif
  output logic [15:0] sample_out,
  output logic        sample_out_valid
);
  logic note_done_q, upd;
  logic [ENV_GAIN_W-1:0] gain;
  env_state_t state;
  logic signed [24:0] prod;
  logic [15:0] sample_out_q;
  logic sample_out_valid_q;
`ifdef ENV_BEAT_RATE_EN
  assign upd = beat & play_enable;
`else
  assign upd = sample_in_valid & play_enable;
`endif
  envelope_gain_fsm #(
    .ATTACK_STEP(ATTACK_STEP), .DECAY_STEP(DECAY_STEP),
    .SUSTAIN_LEVEL(SUSTAIN_LEVEL), .RELEASE_STEP(RELEASE_STEP)
  ) u_fsm (
    .clk(clk), .reset(reset), .upd_i(upd), .note_start_i(note_start),
    .note_done_rise_i(note_done & ~note_done_q), .gain_o(gain), .state_o(state)
  );
  // only the top 8 gain bits scale; zero-extended so the multiplier stays signed
  assign prod = $signed(sample_in) * $signed({1'b0, 8'(gain >> 8)});
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_done_q <= 1'b0;
      sample_out_q <= '0;
      sample_out_valid_q <= 1'b0;
    end else begin
      note_done_q <= note_done;
      sample_out_valid_q <= sample_in_valid;
      if (sample_in_valid) sample_out_q <= 16'(prod >>> 8);
    end
  end
  assign sample_out = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
endmodule

// File: tb/tb_envelope_shaper.sv
// tb_envelope_shaper: scoreboard bench for envelope_shaper (per-sample build)
module tb_envelope_shaper;
  import synth_pkg::*;
  logic clk = 0, reset = 0, play_enable = 1, note_start = 0, note_done = 0, sample_in_valid = 0;
  logic [15:0] sample_in = 0;
  logic [15:0] sample_out;
  logic sample_out_valid;
  int checks = 0, passed = 0;
  logic [15:0] q[$];
  logic [15:0] m_gain = 0;
  env_state_t m_state = IDLE;
  logic m_ndp = 0;
  always #5 clk = ~clk;
  envelope_shaper dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .note_start(note_start),
    .note_done(note_done), .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid)
  );
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [15:0] g);
    logic signed [24:0] p;
    p = $signed(s) * $signed({1'b0, g[15:8]});
    return p[23:8];
  endfunction
  always @(negedge clk) begin
    if (reset && sample_out_valid) begin
      checks++;
      if (q.size() == 0) $display("FAIL scoreboard: unexpected output %h, none expected", sample_out);
      else begin
        logic [15:0] e;
        e = q.pop_front();
        if (sample_out !== e) $display("FAIL scoreboard: got %h want %h", sample_out, e);
        else passed++;
      end
    end
  end
  task automatic cycle(input logic [15:0] s, input logic v, input logic ns, input logic nd);
    logic rise;
    logic [16:0] t;
    sample_in = s; sample_in_valid = v; note_start = ns; note_done = nd;
    rise = nd & ~m_ndp;
    m_ndp = nd;
    if (v) q.push_back(scale(s, m_gain));
    if (ns) m_state = ATTACK;
    else if (rise && m_state inside {ATTACK, DECAY, SUSTAIN}) m_state = RELEASE;
    else if (v && play_enable) begin
      case (m_state)
        IDLE: m_gain = 0;
        ATTACK: begin
          t = m_gain + 17'h400;
          if (t >= 17'hFFFF) begin m_gain = 16'hFFFF; m_state = DECAY; end
          else m_gain = t[15:0];
        end
        DECAY: if (m_gain <= 16'hC100) begin m_gain = 16'hC000; m_state = SUSTAIN; end else m_gain -= 16'h100;
        RELEASE: if (m_gain <= 16'h80) begin m_gain = 0; m_state = IDLE; end else m_gain -= 16'h80;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    sample_in_valid = 0; note_start = 0;
  endtask
  task automatic enter_reset();
    reset = 0; note_done = 0; q.delete();
    m_gain = 0; m_state = IDLE; m_ndp = 0;
  endtask
  task automatic to_sustain(input logic nd);
    int n = 0;
    while (m_state != SUSTAIN && n < 400) begin cycle(16'h4000, 1, 0, nd); n++; end
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {SUSTAIN, 16'hC000}) $display("FAIL to_sustain: state/gain %0d/%h want %0d/C000", dut.u_fsm.state_q, dut.u_fsm.gain_q, SUSTAIN);
    else passed++;
  endtask
  task automatic test_reset();
    enter_reset();
    #2;
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out, sample_out_valid} !== {IDLE, 16'h0, 16'h0, 1'b0}) $display("FAIL reset_init: state %0d gain %h out %h vld %b want all zero", dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out, sample_out_valid);
    else passed++;
    @(posedge clk); #1; reset = 1;
    cycle(0, 0, 1, 0);
    repeat (8) cycle(16'h4000, 1, 0, 0);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {ATTACK, 16'h2000}) $display("FAIL reset_pre: state %0d gain %h want ATTACK 2000", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
    #2; enter_reset(); #1;
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out, sample_out_valid} !== {IDLE, 16'h0, 16'h0, 1'b0}) $display("FAIL reset_async: state %0d gain %h out %h vld %b want all zero", dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out, sample_out_valid);
    else passed++;
    @(posedge clk); #1; reset = 1;
    cycle(16'h4000, 1, 0, 0);
    checks++;
    if ({sample_out_valid, sample_out} !== {1'b1, 16'h0}) $display("FAIL reset_first_sample: vld %b out %h want 1 0000", sample_out_valid, sample_out);
    else passed++;
  endtask
  task automatic test_attack();
    cycle(0, 0, 1, 0);
    repeat (64) cycle(16'h4000, 1, 0, 0);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {DECAY, 16'hFFFF}) $display("FAIL attack_peak: state %0d gain %h want DECAY FFFF", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
    cycle(16'h4000, 1, 0, 0);
    checks++;
    if (sample_out !== 16'h3FC0) $display("FAIL attack_out: got %h want 3FC0", sample_out);
    else passed++;
  endtask
  task automatic test_sustain();
    to_sustain(0);
    cycle(16'h4000, 1, 0, 0);
    checks++;
    if (sample_out !== 16'h3000) $display("FAIL sustain_pos: got %h want 3000", sample_out);
    else passed++;
    cycle(16'hC000, 1, 0, 0);
    checks++;
    if (sample_out !== 16'hD000) $display("FAIL sustain_neg: got %h want D000", sample_out);
    else passed++;
  endtask
  task automatic test_release();
    cycle(0, 0, 0, 1);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {RELEASE, 16'hC000}) $display("FAIL release_enter: state %0d gain %h want RELEASE C000", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
    repeat (384) cycle(16'h4000, 1, 0, 1);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {IDLE, 16'h0}) $display("FAIL release_end: state %0d gain %h want IDLE 0000", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
    cycle(16'h4000, 1, 0, 1);
    checks++;
    if ({dut.u_fsm.state_q, sample_out} !== {IDLE, 16'h0}) $display("FAIL release_idle_out: state %0d out %h want IDLE 0000", dut.u_fsm.state_q, sample_out);
    else passed++;
  endtask
  task automatic test_retrigger();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    to_sustain(0);
    cycle(0, 0, 0, 1);
    repeat (128) cycle(16'h4000, 1, 0, 1);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {RELEASE, 16'h8000}) $display("FAIL retrig_pre: state %0d gain %h want RELEASE 8000", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
    cycle(0, 0, 1, 1);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {ATTACK, 16'h8000}) $display("FAIL retrig_enter: state %0d gain %h want ATTACK 8000", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
    cycle(16'h4000, 1, 0, 1);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out} !== {ATTACK, 16'h8400, 16'h2000}) $display("FAIL retrig_step: state %0d gain %h out %h want ATTACK 8400 2000", dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out);
    else passed++;
    cycle(0, 0, 0, 0);
    to_sustain(0);
    cycle(0, 0, 1, 1);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q} !== {ATTACK, 16'hC000}) $display("FAIL retrig_same_cycle: state %0d gain %h want ATTACK C000", dut.u_fsm.state_q, dut.u_fsm.gain_q);
    else passed++;
  endtask
  task automatic test_freeze();
    enter_reset();
    #2; reset = 1;
    @(posedge clk); #1;
    cycle(0, 0, 1, 0);
    repeat (4) cycle(16'h4000, 1, 0, 0);
    play_enable = 0;
    repeat (10) cycle(16'h4000, 1, 0, 0);
    checks++;
    if ({dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out} !== {ATTACK, 16'h1000, 16'h0400}) $display("FAIL freeze: state %0d gain %h out %h want ATTACK 1000 0400", dut.u_fsm.state_q, dut.u_fsm.gain_q, sample_out);
    else passed++;
    play_enable = 1;
  endtask
  initial begin
    test_reset();
    test_attack();
    test_sustain();
    test_release();
    test_retrigger();
    test_freeze();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: %0d outputs missing, want 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
